// File: rtl/bcd_mmss_timer.sv
// BCD minutes:seconds timer counting down to 0:00 or up to a loaded target.
// A prescaler divides Clk into one-second ticks; Done is sticky until Load or reset.
module bcd_mmss_timer #(
    parameter int MIN_DIGITS = 1,
    parameter int TICK_DIV   = 1
) (
    input  logic                    Clk,
    input  logic                    nReset,
    input  logic                    CounterEnable,
    input  logic                    CountUp,
    input  logic                    Load,
    input  logic [4*MIN_DIGITS-1:0] CounterInput,
    output logic [3:0]              S1,
    output logic [3:0]              S2,
    output logic [4*MIN_DIGITS-1:0] SM,
    output logic                    Done,
    output logic                    Tick,
    output logic [1:0]              DebugState
);

    localparam int MW = 4 * MIN_DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateType;

    stateType        state, nextState;
    logic            modeUp;
    logic [MW-1:0]   target;
    logic [PW-1:0]   presc;

    logic [MW-1:0]   clampedIn;
    logic [MW-1:0]   smInc, smDec;
    logic [3:0]      nextS1, nextS2;
    logic [MW-1:0]   nextSM;
    logic            atTerminal, nextIsTerminal, tickNow;

    assign DebugState = state;
    assign tickNow    = (state == RUN) && CounterEnable && (presc == PRESC_LAST);

    // Digit-wise clamp and ripple carry/borrow across the BCD minute digits.
    always_comb begin
        logic carry;
        logic borrow;
        clampedIn = CounterInput;
        smInc     = SM;
        smDec     = SM;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int d = 0; d < MIN_DIGITS; d++) begin
            if (CounterInput[4*d +: 4] > 4'd9) clampedIn[4*d +: 4] = 4'd9;
            if (carry) begin
                if (SM[4*d +: 4] >= 4'd9) begin
                    smInc[4*d +: 4] = 4'd0;
                end else begin
                    smInc[4*d +: 4] = SM[4*d +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (SM[4*d +: 4] == 4'd0) begin
                    smDec[4*d +: 4] = 4'd9;
                end else begin
                    smDec[4*d +: 4] = SM[4*d +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        nextS1 = S1;
        nextS2 = S2;
        nextSM = SM;
        if (modeUp) begin
            if (S1 < 4'd9) begin
                nextS1 = S1 + 4'd1;
            end else begin
                nextS1 = 4'd0;
                if (S2 < 4'd5) begin
                    nextS2 = S2 + 4'd1;
                end else begin
                    nextS2 = 4'd0;
                    nextSM = smInc;
                end
            end
        end else begin
            if (S1 != 4'd0) begin
                nextS1 = S1 - 4'd1;
            end else begin
                nextS1 = 4'd9;
                if (S2 != 4'd0) begin
                    nextS2 = S2 - 4'd1;
                end else begin
                    nextS2 = 4'd5;
                    nextSM = smDec;
                end
            end
        end
        atTerminal     = (S1 == 4'd0) && (S2 == 4'd0) && (SM == (modeUp ? target : '0));
        nextIsTerminal = (nextS1 == 4'd0) && (nextS2 == 4'd0) &&
                         (nextSM == (modeUp ? target : '0));
    end

    always_comb begin
        nextState = state;
        if (Load) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE: if (CounterEnable) nextState = RUN;
                RUN: begin
                    if (!CounterEnable)                             nextState = IDLE;
                    else if (tickNow && (atTerminal || nextIsTerminal)) nextState = DONE;
                end
                DONE:    nextState = DONE;
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= nextState;
    end

    // Load wins over a coincident tick; the tick is simply dropped.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            S1     <= 4'd0;
            S2     <= 4'd0;
            SM     <= '0;
            Done   <= 1'b0;
            Tick   <= 1'b0;
            presc  <= '0;
            modeUp <= 1'b0;
            target <= '0;
        end else if (Load) begin
            modeUp <= CountUp;
            target <= clampedIn;
            presc  <= '0;
            Done   <= 1'b0;
            Tick   <= 1'b0;
            S1     <= 4'd0;
            S2     <= 4'd0;
            SM     <= CountUp ? '0 : clampedIn;
        end else if (tickNow) begin
            Tick  <= 1'b1;
            presc <= '0;
            if (!atTerminal) begin
                S1 <= nextS1;
                S2 <= nextS2;
                SM <= nextSM;
            end
            if (atTerminal || nextIsTerminal) Done <= 1'b1;
        end else begin
            Tick <= 1'b0;
            if (state == RUN && CounterEnable) presc <= presc + PW'(1);
        end
    end

endmodule
